mult_share_ctrl: RTL

//  Shares one iterative 32x32 Multiplier32 between NREQ requesters (CPU core, display/debug, spare).

---
 rtl/mult_ctrl_pkg.sv | 15 +
 rtl/mult_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/mult_share_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and sizes for the multiplier-sharing controller.
// State encoding, operand/product widths and the default watchdog limit.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int OPND_W      = 32;
    localparam int PROD_W      = 64;
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
// Produces both the one-hot grant and its encoded index.
module rr_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] cand;

    // Walk from farthest to nearest so the candidate closest after ptr wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_id    = cand;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one iterative 32x32 multiplier between NREQ requesters with round-robin
// arbitration, level-held begin/end sequencing, a watchdog and an ID-tagged response.
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*OPND_W-1:0]   req_op1,
    input  logic [NREQ*OPND_W-1:0]   req_op2,
    output logic [NREQ-1:0]          req_ready,
    output logic                     resp_valid,
    output logic [IDW-1:0]           resp_id,
    output logic [PROD_W-1:0]        resp_product,
    output logic                     resp_error,
    input  logic                     resp_ready,
    output logic                     mult_begin,
    output logic [OPND_W-1:0]        mult_operand1,
    output logic [OPND_W-1:0]        mult_operand2,
    input  logic [PROD_W-1:0]        mult_product,
    input  logic                     mult_end,
    output logic                     busy
);

    localparam int WDW = $clog2(TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [WDW-1:0]  wdog;
    logic            accept;
    logic            done_ok;
    logic            done_to;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grant is only offered while idle; mult_end wins over a same-cycle watchdog expiry.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mult_end) begin
                    done_ok   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (wdog == WDW'(TIMEOUT - 1)) begin
                    done_to   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mult_begin = (state == ST_BUSY);
    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            ptr           <= IDW'(NREQ - 1);
            wdog          <= '0;
            mult_operand1 <= '0;
            mult_operand2 <= '0;
            resp_id       <= '0;
            resp_product  <= '0;
            resp_error    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mult_operand1 <= req_op1[OPND_W*grant_id +: OPND_W];
                mult_operand2 <= req_op2[OPND_W*grant_id +: OPND_W];
                resp_id       <= grant_id;
                ptr           <= grant_id;
                wdog          <= '0;
            end else if (state == ST_BUSY) begin
                wdog <= wdog + 1'b1;
            end
            // Result registers stay frozen through RESP until the next run completes.
            if (done_ok) begin
                resp_product <= mult_product;
                resp_error   <= 1'b0;
            end else if (done_to) begin
                resp_product <= '0;
                resp_error   <= 1'b1;
            end
        end
    end

endmodule
